// File: rtl/router_out_arbiter_if.sv
// Handshake bundle between the router input directions, one output-port arbiter and its downstream link.
// The slave modport is the arbiter's view; the master modport is the requester and sink side.
interface router_out_arbiter_if #(
  parameter int WIDTH  = 33,
  parameter int NUM_IN = 5
);
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/router_out_arbiter.sv
// Round-robin arbiter with a single registered output slot for one router output port.
// Optional per-requester saturating grant counters are built when ARB_GRANT_CNT_EN is defined.
module router_out_arbiter #(
  parameter int WIDTH  = 33,
  parameter int NUM_IN = 5
`ifdef ARB_GRANT_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  router_out_arbiter_if.slave     bus
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [NUM_IN*CNT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       state_p0;
  logic [WIDTH-1:0] data_p0;
  logic [IDX_W-1:0] rr_last;

  logic             load_ok;
  logic             win;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  logic [NUM_IN-1:0] grant;
  logic [WIDTH-1:0] win_data;

  // Stage p0 input: arbitration is purely combinational so in_ready answers in the same cycle
  assign load_ok = !reset && ((state_p0 == S_EMPTY) || bus.out_ready);

  always_comb begin
    win      = 1'b0;
    win_idx  = rr_last;
    cand_idx = '0;
    grant    = '0;
    if (load_ok) begin
      for (int k = 1; k <= NUM_IN; k++) begin
        cand_idx = IDX_W'((int'(rr_last) + k) % NUM_IN);
        if (!win && bus.in_valid[cand_idx]) begin
          win     = 1'b1;
          win_idx = cand_idx;
        end
      end
    end
    if (win) grant[win_idx] = 1'b1;
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) win_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign bus.in_ready = grant;

  // Stage p0 register: the single output slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= S_EMPTY;
      data_p0  <= '0;
      rr_last  <= IDX_W'(NUM_IN - 1);
    end else if (win) begin
      state_p0 <= S_FULL;
      data_p0  <= win_data;
      rr_last  <= win_idx;
    end else if (bus.out_ready) begin
      state_p0 <= S_EMPTY;
    end
  end

  assign bus.out_valid = (state_p0 == S_FULL);
  assign bus.out_data  = data_p0;

`ifdef ARB_GRANT_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_p0 [NUM_IN];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (reset) begin
        cnt_p0[i] <= '0;
      end else if (grant[i] && bus.in_valid[i]) begin
        cnt_p0[i] <= sat_inc(cnt_p0[i]);
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_p0[g];
  end
`endif

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: a vector table for steady-state arbitration plus
// hand-written sequences for backpressure, mid-operation reset and (optionally) grant counters.
module tb_router_out_arbiter;

  localparam int WIDTH  = 33;
  localparam int NUM_IN = 5;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  router_out_arbiter_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

`ifdef ARB_GRANT_CNT_EN
  logic [NUM_IN*CNT_W-1:0] grant_cnt;

  router_out_arbiter #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .grant_cnt (grant_cnt)
  );
`else
  router_out_arbiter #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  vld;
    logic        ordy;
    int          exp_idx;
    logic        exp_ovld;
    logic [32:0] exp_odata;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [32:0] pkt(input int i);
    return {1'(i & 1), 4'(i + 1), 4'(9 - i), 24'(24'hC0DE00 + i)};
  endfunction

  task automatic add(input logic [4:0] vld, input logic ordy, input int idx,
                     input logic ovld, input logic [32:0] odata);
    vec_t v;
    v.vld = vld; v.ordy = ordy; v.exp_idx = idx; v.exp_ovld = ovld; v.exp_odata = odata;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_data();
    for (int i = 0; i < NUM_IN; i++) bus.in_data[i*WIDTH +: WIDTH] = pkt(i);
  endtask

  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic step(input string tag, input logic [4:0] vld, input logic ordy, input int exp_idx,
                      input logic exp_ovld, input logic [32:0] exp_odata);
    logic [4:0] e;
    e = (exp_idx < 0) ? 5'b0 : 5'(1 << exp_idx);
    bus.in_valid  = vld;
    bus.out_ready = ordy;
    #3;
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(e));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(exp_ovld));
    chk({tag, " out_data"}, 64'(bus.out_data), 64'(exp_odata));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    load_data();

    // Reset state, with every requester asking: in_ready must stay low.
    @(posedge clk);
    #1;
    bus.in_valid = 5'b11111;
    #3;
    chk("reset in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("reset out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset out_data", 64'(bus.out_data), 64'(0));
    reset = 1'b0;

    // Single request with the documented packet format.
    bus.in_data[0 +: WIDTH] = {1'b1, 4'b0010, 4'b1101, 24'h000155};
    step("t1", 5'b00001, 1'b1, 0, 1'b1, 33'h12D000155);
    load_data();

    // Table: round robin from reset, rr_last steering, drain to empty, load while empty, hold.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_IN; i++) add(5'b11111, 1'b1, i, 1'b1, pkt(i));
    add(5'b00100, 1'b1, 2, 1'b1, pkt(2));
    add(5'b10001, 1'b1, 4, 1'b1, pkt(4));
    add(5'b10001, 1'b1, 0, 1'b1, pkt(0));
    add(5'b00000, 1'b1, -1, 1'b0, pkt(0));
    add(5'b01000, 1'b0, 3, 1'b1, pkt(3));
    add(5'b00010, 1'b0, -1, 1'b1, pkt(3));
    add(5'b00010, 1'b1, 1, 1'b1, pkt(1));
    foreach (tbl[n]) begin
      step($sformatf("vec%0d", n), tbl[n].vld, tbl[n].ordy, tbl[n].exp_idx,
           tbl[n].exp_ovld, tbl[n].exp_odata);
    end

    // Backpressure: slot holds pe's packet, then drain and load back-to-back.
    do_reset();
    step("bp fill", 5'b10000, 1'b1, 4, 1'b1, pkt(4));
    for (int c = 0; c < 4; c++) step($sformatf("bp hold%0d", c), 5'b00011, 1'b0, -1, 1'b1, pkt(4));
    step("bp resume0", 5'b00011, 1'b1, 0, 1'b1, pkt(0));
    step("bp resume1", 5'b00011, 1'b1, 1, 1'b1, pkt(1));
    step("bp drain", 5'b00000, 1'b1, -1, 1'b0, pkt(1));

    // Reset while FULL and stalled discards the packet and restores priority to index 0.
    step("rst fill", 5'b00100, 1'b0, 2, 1'b1, pkt(2));
    step("rst hold", 5'b00010, 1'b0, -1, 1'b1, pkt(2));
    reset = 1'b1;
    bus.in_valid = 5'b11111;
    #3;
    chk("rst mid in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("rst mid out_valid", 64'(bus.out_valid), 64'(0));
    reset = 1'b0;
    step("rst after0", 5'b11111, 1'b1, 0, 1'b1, pkt(0));
    step("rst after1", 5'b11111, 1'b1, 1, 1'b1, pkt(1));

`ifdef ARB_GRANT_CNT_EN
    // Grant counters: 20 grants to index 3 saturate a 4-bit counter at 15.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step($sformatf("cnt g%0d", c), 5'b01000, 1'b1, 3, 1'b1, pkt(3));
      if (c == 4) chk("cnt3 after5", 64'(grant_cnt[3*CNT_W +: CNT_W]), 64'(5));
    end
    for (int i = 0; i < NUM_IN; i++)
      chk($sformatf("cnt%0d final", i), 64'(grant_cnt[i*CNT_W +: CNT_W]), 64'((i == 3) ? 15 : 0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
